radix4_booth_seq_multiplier: RTL and testbench
==============================================

Name: radix4_booth_seq_multiplier

Overview:
- Sequential signed radix-4 (modified Booth) multiplier.
- Sits directly downstream of the start/reset pulse generator. It consumes that generator's one-cycle `reset` pulse and the `start` pulse that follows one cycle later.
- Retires two multiplier bits per clock and presents the 2*WIDTH-bit product with a one-cycle `done` pulse.

Parameters:
- WIDTH, 8: operand width in bits, two's complement. Must be even and at least 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset; one clock; no asynchronous reset anywhere in the block.
- start  input  1  one-cycle request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, signed; sampled on the accepting edge only.
- b  input  WIDTH  multiplier, signed; sampled on the accepting edge only.
- product  output  2*WIDTH  signed result; registered, held until the next completion.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse, coincident with `product` update.

Behaviour:
- Reset values: product=0, done=0, busy=0, state=IDLE, iteration counter=0, internal registers=0.
- Reset priority: reset has priority over everything, including a simultaneous start.
- Reset mid-operation: aborts the operation; done is never asserted for it; product keeps 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- Datapath registers:
  - M: multiplicand, sign-extended to WIDTH+2.
  - ACC: accumulator, WIDTH+2 bits.
  - Q: WIDTH+1 bits, initialised {b, 1'b0}.
  - CNT: iteration counter, $clog2(WIDTH/2)+1 bits.
- IDLE with start=1 at edge t0:
  - Load M, Q and ACC=0, CNT=0; go to RUN.
  - busy is high from t0.
- IDLE with start=0: hold all registers.
- RUN, one iteration per cycle:
  - Recode triple Q[2:0] as follows:
    - 000 and 111 add 0.
    - 001 and 010 add +M.
    - 011 adds +2M.
    - 100 adds -2M.
    - 101 and 110 add -M.
  - ACC_new = ACC + selected term, modulo 2^(WIDTH+2).
  - Then arithmetic-shift {ACC_new, Q} right by 2, replicating the ACC sign bit.
  - CNT increments each iteration.
  - After WIDTH/2 iterations (edges t0+1 .. t0+WIDTH/2), go to DONE.
- DONE, edge t0+WIDTH/2+1:
  - product <= lower 2*WIDTH bits of {ACC, Q[WIDTH:1]}; done=1 for that cycle only.
  - Return to IDLE; busy drops on the next edge.
- Latency: done is visible WIDTH/2+1 cycles after the accepting edge (5 for WIDTH=8). Throughput is one result per WIDTH/2+2 cycles.
- start while busy (RUN or DONE): ignored; no queueing; operands are not resampled.
- start in the cycle after done (state IDLE): accepted, giving back-to-back operation.
- Generator sequence (reset one cycle, then start the next cycle): reset clears the block and the following start is accepted normally.
- Extremes: the most-negative × most-negative case must be exact. For WIDTH=8, -128 × -128 = +16384 (0x4000). ACC width WIDTH+2 guarantees no overflow of ±2M terms.
- a or b inputs changing during RUN have no effect.

Decomposition:
- Shared package radix4_pkg holds:
  - State enum (IDLE, RUN, DONE).
  - Booth-op typedef (OP_ZERO, OP_P1, OP_P2, OP_M1, OP_M2).
  - Function/constant for iteration count WIDTH/2.
- One natural sub-module, booth_recoder (combinational):
  - Inputs: 3-bit triple, M.
  - Output: WIDTH+2-bit signed partial term.
  - Reused by a future parallel multiplier.
- FSM, counter and shift datapath stay in the top module.

Test Plan:
- reset pulse, then start with a=7, b=3 on the next cycle -> busy high; done pulses exactly 5 cycles after the start edge; product=21 (0x0015); done low otherwise.
- a=-128, b=-128 -> product=0x4000. Also a=127, b=-1 -> product=0xFF81 (-127).
- a=-5, b=6 -> product=0xFFE2 (-30). Then start in the cycle right after done with a=-5, b=-6 -> second done 5 cycles later; product=0x001E.
- start a=10, b=10; re-assert start with a=3, b=3 during RUN and again in DONE -> single done; product=100 (0x0064); no second done.
- start a=9, b=9; assert reset on the 2nd RUN cycle -> busy=0, done never pulses, product=0. Then start a=2, b=-3 -> product=0xFFFA.
- reset and start asserted in the same cycle -> stays IDLE, busy=0, no done within 10 cycles.

Source files
------------

// File: rtl/radix4_pkg.sv
// Shared types and helpers for radix-4 (modified Booth) multipliers.
// Covers the controller states, the Booth recoding operations and the iteration count.
package radix4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ZERO,
    OP_P1,
    OP_P2,
    OP_M1,
    OP_M2
  } booth_op_t;

  // Radix-4 retires two multiplier bits per iteration.
  function automatic int booth_iters(input int width);
    return width / 2;
  endfunction

  function automatic booth_op_t booth_decode(input logic [2:0] triple);
    booth_op_t op;
    case (triple)
      3'b001, 3'b010: op = OP_P1;
      3'b011:         op = OP_P2;
      3'b100:         op = OP_M2;
      3'b101, 3'b110: op = OP_M1;
      default:        op = OP_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational radix-4 Booth recoder: maps a multiplier bit triple to a
// signed partial term of 0, +/-M or +/-2M.
module booth_recoder
  import radix4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        [2:0]       triple,
  input  logic signed [WIDTH+1:0] m,
  output logic signed [WIDTH+1:0] term
);

  // m carries two guard bits, so doubling and negating cannot overflow.
  logic signed [WIDTH+1:0] m2;

  assign m2 = m <<< 1;

  always_comb begin
    term = '0;
    case (booth_decode(triple))
      OP_P1:   term = m;
      OP_P2:   term = m2;
      OP_M1:   term = -m;
      OP_M2:   term = -m2;
      default: term = '0;
    endcase
  end

endmodule

// File: rtl/radix4_booth_seq_multiplier.sv
// Sequential signed radix-4 Booth multiplier: two multiplier bits per clock,
// registered 2*WIDTH-bit product with a one-cycle done pulse.
module radix4_booth_seq_multiplier
  import radix4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] product,
  output logic                      busy,
  output logic                      done
);

  localparam int ITERS = booth_iters(WIDTH);
  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_t state, state_nxt;

  logic signed [WIDTH+1:0]   m_r;
  logic signed [WIDTH+1:0]   acc_r;
  logic        [WIDTH:0]     q_r;
  logic        [CNT_W-1:0]   cnt_r;

  logic signed [WIDTH+1:0]   term;
  logic signed [WIDTH+1:0]   acc_sum;
  logic signed [2*WIDTH+2:0] shifted;

  booth_recoder #(
    .WIDTH (WIDTH)
  ) u_recoder (
    .triple (q_r[2:0]),
    .m      (m_r),
    .term   (term)
  );

  // Add the recoded term, then shift {ACC, Q} right by two with sign fill.
  assign acc_sum = acc_r + term;
  assign shifted = $signed({acc_sum, q_r}) >>> 2;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt_r == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m_r     <= '0;
      acc_r   <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_r   <= {{2{a[WIDTH-1]}}, a};
            acc_r <= '0;
            q_r   <= {b, 1'b0};
            cnt_r <= '0;
          end
        end
        RUN: begin
          acc_r <= shifted[2*WIDTH+2:WIDTH+1];
          q_r   <= shifted[WIDTH:0];
          cnt_r <= cnt_r + 1'b1;
        end
        DONE: begin
          // High product half sits in ACC, low half in Q above the Booth guard bit.
          product <= {acc_r[WIDTH-1:0], q_r[WIDTH:1]};
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_booth_seq_multiplier.sv
// Directed bench for the sequential radix-4 Booth multiplier (WIDTH=8).
module tb_radix4_booth_seq_multiplier;

  logic               clk;
  logic               reset;
  logic               start;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic signed [15:0] product;
  logic               busy;
  logic               done;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  radix4_booth_seq_multiplier #(
    .WIDTH (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one multiplication, wait (bounded) for done, check latency and product.
  task automatic do_mult(input string tag, input logic signed [7:0] av,
                         input logic signed [7:0] bv, input logic [15:0] exp);
    int lat;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 12);
    check({tag, "_latency"}, lat, 32'd5);
    check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
  endtask

  // Count done pulses over n cycles.
  task automatic count_done(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) seen++;
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Generator sequence: reset pulse, start on the following cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_mult("7x3", 8'sd7, 8'sd3, 16'h0015);
    tick();
    check("7x3_done_drops", {31'd0, done}, 32'd0);

    do_mult("m128xm128", -8'sd128, -8'sd128, 16'h4000);
    do_mult("127xm1", 8'sd127, -8'sd1, 16'hFF81);
    do_mult("m5x6", -8'sd5, 8'sd6, 16'hFFE2);
    // Back-to-back: started in the done cycle.
    do_mult("m5xm6_b2b", -8'sd5, -8'sd6, 16'h001E);

    // start while busy (RUN and DONE) is ignored.
    a = 8'sd10;
    b = 8'sd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'sd3;
    b = 8'sd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("busy_in_done", {31'd0, busy}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignore_done", {31'd0, done}, 32'd1);
    check("ignore_product", {16'd0, product}, 32'h0064);
    count_done(10, seen);
    check("ignore_no_second_done", seen, 32'd0);
    check("ignore_product_held", {16'd0, product}, 32'h0064);

    // Reset in the second RUN cycle aborts the operation.
    a = 8'sd9;
    b = 8'sd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_product", {16'd0, product}, 32'd0);
    count_done(8, seen);
    check("abort_no_done", seen, 32'd0);
    check("abort_product_held", {16'd0, product}, 32'd0);
    do_mult("2xm3", 8'sd2, -8'sd3, 16'hFFFA);

    // Reset wins over a simultaneous start.
    a = 8'sd4;
    b = 8'sd4;
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    count_done(10, seen);
    check("rst_start_no_done", seen, 32'd0);
    check("rst_start_product", {16'd0, product}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
